// File: rtl/tmds_clk_pkg.sv
// Shared types and helpers for the TMDS clock supervisor.
package tmds_clk_pkg;

  typedef enum logic [1:0] {
    RST_MMCM,
    WAIT_LOCK,
    MEASURE,
    ACTIVE
  } chan_state_t;

  // Width of a reported frequency: edge count plus the pixel-divider shift.
  function automatic int unsigned freq_w(input int unsigned cnt_w, input int unsigned div_log2);
    return cnt_w + div_log2;
  endfunction

endpackage

// File: rtl/tmds_clk_chan_mon.sv
// One supervised MMCM channel: input syncs, window/edge counters, reset-lock-measure FSM.
module tmds_clk_chan_mon
  import tmds_clk_pkg::*;
#(
  parameter int unsigned WIN_CYCLES     = 100000,
  parameter int unsigned DIV_LOG2       = 4,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_TO_CYCLES = 1000000,
  parameter int unsigned FMIN_KHZ       = 25000,
  parameter int unsigned FMAX_KHZ       = 165000,
  parameter int unsigned DRIFT_KHZ      = 500,
  localparam int unsigned FW            = freq_w(CNT_W, DIV_LOG2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mmcm_locked,
  input  logic          pix_tgl,
  output logic          mmcm_rst,
  output logic          ch_valid,
  output logic [FW-1:0] freq_khz,
  output logic          freq_upd,
  output logic [7:0]    relock_cnt
);

  localparam int unsigned T1   = (RST_CYCLES > WIN_CYCLES) ? RST_CYCLES : WIN_CYCLES;
  localparam int unsigned TMAX = (T1 > LOCK_TO_CYCLES) ? T1 : LOCK_TO_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  chan_state_t      state, state_nx;
  logic [1:0]       lock_sync;
  logic [2:0]       tgl_sync;
  logic [TW-1:0]    tmr;
  logic [CNT_W-1:0] edge_cnt, cnt_nx;
  logic [FW-1:0]    freq_new;
  logic [31:0]      fn32, fo32, delta;
  logic             locked, tgl_edge, win_end, in_range, drift_bad, upd, relock;

  always_comb begin
    locked    = lock_sync[1];
    tgl_edge  = tgl_sync[2] ^ tgl_sync[1];
    cnt_nx    = (tgl_edge && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
    freq_new  = FW'(cnt_nx) << DIV_LOG2;
    fn32      = 32'(freq_new);
    fo32      = 32'(freq_khz);
    delta     = (fn32 > fo32) ? fn32 - fo32 : fo32 - fn32;
    in_range  = (fn32 >= FMIN_KHZ) && (fn32 <= FMAX_KHZ);
    drift_bad = delta > DRIFT_KHZ;
    win_end   = ((state == MEASURE) || (state == ACTIVE)) && (tmr == TW'(WIN_CYCLES - 1));
  end

  // Lock loss is checked ahead of window end so a coincident loss suppresses the update.
  always_comb begin
    state_nx = state;
    upd      = 1'b0;
    relock   = 1'b0;
    case (state)
      RST_MMCM: begin
        if (tmr == TW'(RST_CYCLES - 1)) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked) begin
          state_nx = MEASURE;
        end else if (tmr == TW'(LOCK_TO_CYCLES - 1)) begin
          state_nx = RST_MMCM;
          relock   = 1'b1;
        end
      end
      MEASURE: begin
        if (!locked) begin
          state_nx = RST_MMCM;
          relock   = 1'b1;
        end else if (win_end) begin
          upd = 1'b1;
          if (in_range) begin
            state_nx = ACTIVE;
          end else begin
            state_nx = RST_MMCM;
            relock   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!locked) begin
          state_nx = RST_MMCM;
          relock   = 1'b1;
        end else if (win_end) begin
          upd = 1'b1;
          if (!in_range || drift_bad) begin
            state_nx = RST_MMCM;
            relock   = 1'b1;
          end
        end
      end
      default: state_nx = RST_MMCM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync  <= '0;
      tgl_sync   <= '0;
      state      <= RST_MMCM;
      tmr        <= '0;
      edge_cnt   <= '0;
      mmcm_rst   <= 1'b1;
      ch_valid   <= 1'b0;
      freq_khz   <= '0;
      freq_upd   <= 1'b0;
      relock_cnt <= '0;
    end else begin
      lock_sync <= {lock_sync[0], mmcm_locked};
      tgl_sync  <= {tgl_sync[1:0], pix_tgl};
      state     <= state_nx;
      tmr       <= ((state_nx != state) || win_end) ? '0 : tmr + TW'(1);
      edge_cnt  <= ((state_nx == state) && !win_end &&
                    ((state == MEASURE) || (state == ACTIVE))) ? cnt_nx : '0;
      mmcm_rst  <= (state_nx == RST_MMCM);
      ch_valid  <= (state_nx == ACTIVE);
      freq_upd  <= upd;
      if (upd) freq_khz <= freq_new;
      if (relock && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tmds_clock_supervisor.sv
// Supervises NUM_CH independent HDMI-RX clock MMCMs and packs per-channel status onto flat buses.
module tmds_clock_supervisor
  import tmds_clk_pkg::*;
#(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned WIN_CYCLES     = 100000,
  parameter int unsigned DIV_LOG2       = 4,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_TO_CYCLES = 1000000,
  parameter int unsigned FMIN_KHZ       = 25000,
  parameter int unsigned FMAX_KHZ       = 165000,
  parameter int unsigned DRIFT_KHZ      = 500,
  localparam int unsigned FW            = freq_w(CNT_W, DIV_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    mmcm_locked,
  input  logic [NUM_CH-1:0]    pix_tgl,
  output logic [NUM_CH-1:0]    mmcm_rst,
  output logic [NUM_CH-1:0]    ch_valid,
  output logic [NUM_CH*FW-1:0] freq_khz,
  output logic [NUM_CH-1:0]    freq_upd,
  output logic [NUM_CH*8-1:0]  relock_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tmds_clk_chan_mon #(
      .WIN_CYCLES    (WIN_CYCLES),
      .DIV_LOG2      (DIV_LOG2),
      .CNT_W         (CNT_W),
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TO_CYCLES(LOCK_TO_CYCLES),
      .FMIN_KHZ      (FMIN_KHZ),
      .FMAX_KHZ      (FMAX_KHZ),
      .DRIFT_KHZ     (DRIFT_KHZ)
    ) u_mon (
      .clk        (clk),
      .rst        (rst),
      .mmcm_locked(mmcm_locked[i]),
      .pix_tgl    (pix_tgl[i]),
      .mmcm_rst   (mmcm_rst[i]),
      .ch_valid   (ch_valid[i]),
      .freq_khz   (freq_khz[i*FW +: FW]),
      .freq_upd   (freq_upd[i]),
      .relock_cnt (relock_cnt[i*8 +: 8])
    );
  end

endmodule

// File: tb/tb_tmds_clock_supervisor.sv
// Self-checking bench: MMCM/pixel-clock environment model plus per-scenario checks.
module tb_tmds_clock_supervisor;

  localparam int unsigned WIN = 256, DIV = 2, CW = 8, RSTC = 16, LTO = 300;
  localparam int unsigned FMIN = 128, FMAX = 512, DRIFT = 8, FW = CW + DIV;
  localparam int LOCK_DLY = 50;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mmcm_locked = '0;
  logic [1:0]      pix_tgl = '0;
  logic [1:0]      mmcm_rst, ch_valid, freq_upd;
  logic [2*FW-1:0] freq_khz;
  logic [15:0]     relock_cnt;

  int pass_cnt = 0, chk_cnt = 0;
  // Environment controls, written only by the test sequence.
  int per[2]       = '{0, 0};
  int lmode[2]     = '{0, 0};   // 0: never locks, 1: locks LOCK_DLY after mmcm_rst falls, 2: always locked
  int drop_from[2] = '{0, 0};
  int drop_len[2]  = '{0, 0};
  // Environment state, owned by the environment process.
  int cyc = 0;
  int pcnt[2] = '{0, 0};
  int lowc[2] = '{0, 0};

  tmds_clock_supervisor #(
    .NUM_CH(2), .WIN_CYCLES(WIN), .DIV_LOG2(DIV), .CNT_W(CW), .RST_CYCLES(RSTC),
    .LOCK_TO_CYCLES(LTO), .FMIN_KHZ(FMIN), .FMAX_KHZ(FMAX), .DRIFT_KHZ(DRIFT)
  ) dut (
    .clk(clk), .rst(rst), .mmcm_locked(mmcm_locked), .pix_tgl(pix_tgl),
    .mmcm_rst(mmcm_rst), .ch_valid(ch_valid), .freq_khz(freq_khz),
    .freq_upd(freq_upd), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      logic lk;
      if (per[i] == 0) pcnt[i] = 0;
      else begin
        pcnt[i] = pcnt[i] + 1;
        if (pcnt[i] >= per[i]) begin
          pcnt[i] = 0;
          pix_tgl[i] = ~pix_tgl[i];
        end
      end
      lowc[i] = mmcm_rst[i] ? 0 : lowc[i] + 1;
      case (lmode[i])
        0:       lk = 1'b0;
        1:       lk = (lowc[i] >= LOCK_DLY);
        default: lk = 1'b1;
      endcase
      if (cyc >= drop_from[i] && cyc < drop_from[i] + drop_len[i]) lk = 1'b0;
      mmcm_locked[i] = lk;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Reference model: a window of WIN cycles holds WIN/per toggles when per divides WIN.
  function automatic int exp_freq(input int p);
    int e;
    if (p == 0) return 0;
    e = WIN / p;
    if (e > (1 << CW) - 1) e = (1 << CW) - 1;
    return e << DIV;
  endfunction

  function automatic int fk(input int ch);
    return int'(freq_khz[ch*FW +: FW]);
  endfunction

  function automatic int rc(input int ch);
    return int'(relock_cnt[ch*8 +: 8]);
  endfunction

  function automatic int rand_per();
    case ($urandom_range(0, 2))
      0:       return 2;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_upd(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (freq_upd[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drop_lock(input int ch, input int len);
    drop_from[ch] = cyc + 1;
    drop_len[ch]  = len;
  endtask

  task automatic test_reset();
    per = '{0, 0};
    lmode = '{0, 0};
    do_reset();
    chk_cnt++; if (mmcm_rst !== 2'b11) $display("FAIL reset_mmcm_rst: got %b expected 11", mmcm_rst); else pass_cnt++;
    chk_cnt++; if (ch_valid !== 2'b00) $display("FAIL reset_ch_valid: got %b expected 00", ch_valid); else pass_cnt++;
    chk_cnt++; if (freq_khz !== '0) $display("FAIL reset_freq: got %0d expected 0", freq_khz); else pass_cnt++;
    chk_cnt++; if (freq_upd !== 2'b00) $display("FAIL reset_upd: got %b expected 00", freq_upd); else pass_cnt++;
    chk_cnt++; if (relock_cnt !== '0) $display("FAIL reset_relock: got %0d expected 0", relock_cnt); else pass_cnt++;
  endtask

  task automatic test_lock_active();
    bit ok;
    int p, n;
    p = rand_per();
    per = '{p, 0};
    lmode = '{1, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL active_first_upd: got no update expected update"); else pass_cnt++;
    chk_cnt++; if (fk(0) !== exp_freq(p)) $display("FAIL active_freq: got %0d expected %0d", fk(0), exp_freq(p)); else pass_cnt++;
    chk_cnt++; if (ch_valid[0] !== 1'b1) $display("FAIL active_valid: got %b expected 1", ch_valid[0]); else pass_cnt++;
    n = 0;
    do begin tick(); n++; end while (!freq_upd[0] && n < 2 * WIN);
    chk_cnt++; if (n !== WIN) $display("FAIL active_upd_period: got %0d expected %0d", n, WIN); else pass_cnt++;
    chk_cnt++; if (fk(0) !== exp_freq(p)) $display("FAIL active_freq2: got %0d expected %0d", fk(0), exp_freq(p)); else pass_cnt++;
    chk_cnt++; if (ch_valid[0] !== 1'b1 || rc(0) !== 0) $display("FAIL active_hold: got valid=%b relock=%0d expected 1/0", ch_valid[0], rc(0)); else pass_cnt++;
  endtask

  task automatic test_static_clock();
    bit ok, saw_valid;
    int n;
    per = '{0, 0};
    lmode = '{2, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL static_upd: got no update expected update"); else pass_cnt++;
    chk_cnt++; if (fk(0) !== 0) $display("FAIL static_freq: got %0d expected 0", fk(0)); else pass_cnt++;
    chk_cnt++; if (rc(0) !== 1) $display("FAIL static_relock: got %0d expected 1", rc(0)); else pass_cnt++;
    n = 0;
    saw_valid = ch_valid[0];
    while (mmcm_rst[0] && n < 100) begin
      tick();
      n++;
      saw_valid |= ch_valid[0];
    end
    chk_cnt++; if (n !== RSTC) $display("FAIL static_rst_width: got %0d expected %0d", n, RSTC); else pass_cnt++;
    chk_cnt++; if (saw_valid !== 1'b0) $display("FAIL static_valid: got 1 expected 0"); else pass_cnt++;
  endtask

  task automatic test_saturation();
    bit ok;
    per = '{1, 0};
    lmode = '{2, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || fk(0) !== exp_freq(1)) $display("FAIL sat_freq: got %0d expected %0d", fk(0), exp_freq(1)); else pass_cnt++;
    chk_cnt++; if (ch_valid[0] !== 1'b0 || rc(0) !== 1) $display("FAIL sat_relock: got valid=%b relock=%0d expected 0/1", ch_valid[0], rc(0)); else pass_cnt++;
  endtask

  task automatic test_no_lock();
    int n;
    per = '{0, 0};
    lmode = '{0, 0};
    do_reset();
    n = 0;
    while (mmcm_rst[0] && n < 100) begin tick(); n++; end
    chk_cnt++; if (n !== RSTC) $display("FAIL nolock_first_rst: got %0d expected %0d", n, RSTC); else pass_cnt++;
    for (int k = 1; k <= 2; k++) begin
      n = 0;
      while (!mmcm_rst[0] && n < 1000) begin tick(); n++; end
      chk_cnt++; if (n !== LTO) $display("FAIL nolock_wait_len: got %0d expected %0d", n, LTO); else pass_cnt++;
      chk_cnt++; if (rc(0) !== k || rc(1) !== k) $display("FAIL nolock_relock: got %0d/%0d expected %0d", rc(0), rc(1), k); else pass_cnt++;
      n = 0;
      while (mmcm_rst[0] && n < 100) begin tick(); n++; end
      chk_cnt++; if (n !== RSTC) $display("FAIL nolock_rst_width: got %0d expected %0d", n, RSTC); else pass_cnt++;
    end
  endtask

  task automatic test_lock_drop();
    bit ok;
    int p, n;
    p = rand_per();
    per = '{p, 0};
    lmode = '{1, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || ch_valid[0] !== 1'b1) $display("FAIL drop_pre_active: got valid=%b expected 1", ch_valid[0]); else pass_cnt++;
    repeat ($urandom_range(5, WIN - 20)) tick();
    drop_lock(0, 3);
    n = 0;
    do begin tick(); n++; end while (ch_valid[0] && n < 10);
    chk_cnt++; if (n > 3 || mmcm_rst[0] !== 1'b1) $display("FAIL drop_latency: got %0d cycles rst=%b expected <=3 and 1", n, mmcm_rst[0]); else pass_cnt++;
    chk_cnt++; if (rc(0) !== 1) $display("FAIL drop_relock: got %0d expected 1", rc(0)); else pass_cnt++;
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || ch_valid[0] !== 1'b1 || fk(0) !== exp_freq(p)) $display("FAIL drop_recover: got valid=%b freq=%0d expected 1/%0d", ch_valid[0], fk(0), exp_freq(p)); else pass_cnt++;
  endtask

  task automatic test_loss_at_window_end();
    bit ok, saw_upd;
    int f0;
    per = '{8, 0};
    lmode = '{1, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || ch_valid[0] !== 1'b1 || fk(0) !== FMIN) $display("FAIL edge_fmin_accept: got valid=%b freq=%0d expected 1/%0d", ch_valid[0], fk(0), FMIN); else pass_cnt++;
    f0 = fk(0);
    repeat (WIN - 3) tick();
    drop_lock(0, 3);
    saw_upd = 1'b0;
    repeat (3) begin
      tick();
      saw_upd |= freq_upd[0];
    end
    chk_cnt++; if (saw_upd !== 1'b0 || fk(0) !== f0) $display("FAIL edge_no_upd: got upd=%b freq=%0d expected 0/%0d", saw_upd, fk(0), f0); else pass_cnt++;
    chk_cnt++; if (ch_valid[0] !== 1'b0 || mmcm_rst[0] !== 1'b1 || rc(0) !== 1) $display("FAIL edge_relock: got valid=%b rst=%b relock=%0d expected 0/1/1", ch_valid[0], mmcm_rst[0], rc(0)); else pass_cnt++;
  endtask

  task automatic test_freq_switch();
    bit ok;
    int fsw;
    per = '{8, 0};
    lmode = '{1, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    wait_upd(0, WIN + 5, ok);
    chk_cnt++; if (ok !== 1'b1 || ch_valid[0] !== 1'b1) $display("FAIL switch_pre_active: got valid=%b expected 1", ch_valid[0]); else pass_cnt++;
    per[0] = 4;
    wait_upd(0, WIN + 5, ok);
    fsw = fk(0);
    chk_cnt++; if (ok !== 1'b1 || fsw < 240 || fsw > 264) $display("FAIL switch_window: got %0d expected 240..264", fsw); else pass_cnt++;
    chk_cnt++; if (ch_valid[0] !== 1'b0 || mmcm_rst[0] !== 1'b1 || rc(0) !== 1) $display("FAIL switch_relock: got valid=%b rst=%b relock=%0d expected 0/1/1", ch_valid[0], mmcm_rst[0], rc(0)); else pass_cnt++;
    repeat (5) tick();
    chk_cnt++; if (fk(0) !== fsw) $display("FAIL switch_hold: got %0d expected %0d", fk(0), fsw); else pass_cnt++;
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || fk(0) !== exp_freq(4) || ch_valid[0] !== 1'b1) $display("FAIL switch_recover: got freq=%0d valid=%b expected %0d/1", fk(0), ch_valid[0], exp_freq(4)); else pass_cnt++;
  endtask

  task automatic test_multi_channel();
    bit ok;
    int p, n;
    p = rand_per();
    per = '{p, 0};
    lmode = '{1, 0};
    do_reset();
    wait_upd(0, 1000, ok);
    n = 0;
    while (rc(1) == 0 && n < 800) begin tick(); n++; end
    chk_cnt++; if (rc(1) == 0) $display("FAIL multi_ch1_retry: got 0 expected >=1"); else pass_cnt++;
    chk_cnt++; if (ok !== 1'b1 || ch_valid !== 2'b01 || rc(0) !== 0 || fk(0) !== exp_freq(p)) $display("FAIL multi_ch0_indep: got valid=%b relock0=%0d freq=%0d expected 01/0/%0d", ch_valid, rc(0), fk(0), exp_freq(p)); else pass_cnt++;
    drop_lock(0, 3);
    n = 0;
    while (!mmcm_rst[0] && n < 20) begin tick(); n++; end
    while (mmcm_rst[0] && n < 100) begin tick(); n++; end
    repeat (LOCK_DLY + 10 + $urandom_range(0, 150)) tick();
    chk_cnt++; if (ch_valid[0] !== 1'b0 || mmcm_rst[0] !== 1'b0 || rc(0) !== 1) $display("FAIL multi_measuring: got valid=%b rst=%b relock=%0d expected 0/0/1", ch_valid[0], mmcm_rst[0], rc(0)); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (mmcm_rst !== 2'b11 || ch_valid !== 2'b00 || freq_upd !== 2'b00) $display("FAIL multi_rst_ctrl: got rst=%b valid=%b upd=%b expected 11/00/00", mmcm_rst, ch_valid, freq_upd); else pass_cnt++;
    chk_cnt++; if (freq_khz !== '0 || relock_cnt !== '0) $display("FAIL multi_rst_regs: got freq=%0d relock=%0d expected 0/0", freq_khz, relock_cnt); else pass_cnt++;
    tick();
    rst = 1'b0;
    wait_upd(0, 1000, ok);
    chk_cnt++; if (ok !== 1'b1 || fk(0) !== exp_freq(p) || ch_valid[0] !== 1'b1 || rc(0) !== 0) $display("FAIL multi_recover: got freq=%0d valid=%b relock=%0d expected %0d/1/0", fk(0), ch_valid[0], rc(0), exp_freq(p)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock_active();
    test_static_clock();
    test_saturation();
    test_no_lock();
    test_lock_drop();
    test_loss_at_window_end();
    test_freq_switch();
    test_multi_channel();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
